// File: rtl/shot_clock_ctrl.sv
// Shot-clock controller: edge-triggered (re)start from a full or short preset,
// pausable countdown with prescaled ticks, and a fixed-length buzz on expiry.
module shot_clock_ctrl #(
   parameter int CNT_W        = 4,
   parameter int PRESET       = 10,
   parameter int SHORT_PRESET = 5,
   parameter int TICK_DIV     = 1,
   parameter int BUZZ_LEN     = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             shoot,
   input  logic             hold,
   input  logic             reload_short,
   output logic [CNT_W-1:0] count,
   output logic             buzz,
   output logic             running
);

   localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int BUZ_W = (BUZZ_LEN > 1) ? $clog2(BUZZ_LEN) : 1;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] RUN     = 2'd1;
   localparam logic [1:0] PAUSE   = 2'd2;
   localparam logic [1:0] EXPIRED = 2'd3;

   localparam logic [CNT_W-1:0] FULL_VAL  = CNT_W'(PRESET);
   localparam logic [CNT_W-1:0] SHORT_VAL = CNT_W'(SHORT_PRESET);
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
   localparam logic [BUZ_W-1:0] BUZ_LAST  = BUZ_W'(BUZZ_LEN - 1);

   logic [1:0]       state, state_n;
   logic [CNT_W-1:0] count_n;
   logic [DIV_W-1:0] div, div_n;
   logic [BUZ_W-1:0] bcnt, bcnt_n;
   logic             buzz_n;
   logic             shoot_s, short_s, shoot_q;
   logic             shoot_edge, tick;
   logic [CNT_W-1:0] load_val;

   // reload_short is captured together with shoot so the preset choice stays
   // aligned with the edge it belongs to.
   assign shoot_edge = shoot_s & ~shoot_q;
   assign load_val   = short_s ? SHORT_VAL : FULL_VAL;
   assign tick       = (state == RUN) && (div == DIV_LAST);

   always_comb begin
      state_n = state;
      count_n = count;
      div_n   = div;
      bcnt_n  = bcnt;
      buzz_n  = buzz;
      case (state)
         IDLE: begin
            count_n = FULL_VAL;
            if (shoot_edge) begin
               state_n = RUN;
               count_n = load_val;
               div_n   = '0;
            end
         end
         RUN: begin
            if (shoot_edge) begin
               count_n = load_val;
               div_n   = '0;
            end else if (hold) begin
               state_n = PAUSE;
            end else begin
               div_n = tick ? '0 : div + 1'b1;
               // Expiry happens on the tick that would take the count from 1 to 0.
               if (tick && count == CNT_W'(1)) begin
                  count_n = '0;
                  buzz_n  = 1'b1;
                  bcnt_n  = '0;
                  state_n = EXPIRED;
               end else if (tick && count != '0) begin
                  count_n = count - 1'b1;
               end
            end
         end
         PAUSE: begin
            if (shoot_edge) begin
               count_n = load_val;
               div_n   = '0;
            end else if (!hold) begin
               state_n = RUN;
            end
         end
         EXPIRED: begin
            count_n = '0;
            if (bcnt == BUZ_LAST) begin
               buzz_n  = 1'b0;
               count_n = FULL_VAL;
               state_n = IDLE;
            end else begin
               bcnt_n = bcnt + 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
            count_n = FULL_VAL;
            buzz_n  = 1'b0;
         end
      endcase
   end

   // running decodes the next state so it changes on the same edge as the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         count   <= FULL_VAL;
         div     <= '0;
         bcnt    <= '0;
         buzz    <= 1'b0;
         running <= 1'b0;
         shoot_s <= 1'b0;
         short_s <= 1'b0;
         shoot_q <= 1'b0;
      end else begin
         state   <= state_n;
         count   <= count_n;
         div     <= div_n;
         bcnt    <= bcnt_n;
         buzz    <= buzz_n;
         running <= (state_n == RUN);
         shoot_s <= shoot;
         short_s <= reload_short;
         shoot_q <= shoot_s;
      end
   end

endmodule

// File: tb/tb_shot_clock_ctrl.sv
// Directed bench for shot_clock_ctrl: expected outputs are queued per cycle by
// the stimulus and compared by an independent negedge monitor.
module tb_shot_clock_ctrl;

   logic       clock = 1'b0;
   logic       rstN = 1'b0;
   logic       shoot = 1'b0;
   logic       hold = 1'b0;
   logic       reloadShort = 1'b0;
   logic [3:0] countA, countB;
   logic       buzzA, buzzB, runningA, runningB;

   typedef struct {
      bit sel;
      int tag;
      int cnt;
      bit bz;
      bit rn;
   } exp_t;

   exp_t expQ[$];
   exp_t monE;
   int   checks = 0;
   int   errors = 0;
   int   gotCnt;
   bit   gotBz, gotRn;

   shot_clock_ctrl dutA (
      .clk(clock), .rst_n(rstN), .shoot(shoot), .hold(hold),
      .reload_short(reloadShort), .count(countA), .buzz(buzzA), .running(runningA)
   );

   shot_clock_ctrl #(.TICK_DIV(4)) dutB (
      .clk(clock), .rst_n(rstN), .shoot(shoot), .hold(hold),
      .reload_short(reloadShort), .count(countB), .buzz(buzzB), .running(runningB)
   );

   always #5 clock = ~clock;

   // Monitor: one queued expectation is consumed per falling edge.
   always @(negedge clock) begin
      if (expQ.size() > 0) begin
         monE   = expQ.pop_front();
         gotCnt = monE.sel ? int'(countB) : int'(countA);
         gotBz  = monE.sel ? buzzB : buzzA;
         gotRn  = monE.sel ? runningB : runningA;
         checks++;
         if (gotCnt != monE.cnt || gotBz != monE.bz || gotRn != monE.rn) begin
            errors++;
            $display("[TB] FAIL t%0d dut%s count/buzz/running got %0d/%0d/%0d expected %0d/%0d/%0d",
                     monE.tag, monE.sel ? "B" : "A", gotCnt, gotBz, gotRn,
                     monE.cnt, monE.bz, monE.rn);
         end
      end
   end

   task automatic applyStimulus(input bit s, input bit h, input bit rs);
      shoot       = s;
      hold        = h;
      reloadShort = rs;
   endtask

   task automatic pushExp(input int tag, input bit sel, input int c, input bit b, input bit r);
      exp_t e;
      e.sel = sel;
      e.tag = tag;
      e.cnt = c;
      e.bz  = b;
      e.rn  = r;
      expQ.push_back(e);
   endtask

   task automatic checkOutput(input int tag, input bit sel, input int c, input bit b, input bit r);
      @(posedge clock);
      #1;
      pushExp(tag, sel, c, b, r);
   endtask

   task automatic idleCycle();
      @(posedge clock);
      #1;
   endtask

   // Asserts reset between edges and expects reset values before the next edge.
   task automatic resetStep(input int tag, input bit sel);
      @(posedge clock);
      #2;
      rstN = 1'b0;
      #1;
      pushExp(tag, sel, 10, 1'b0, 1'b0);
   endtask

   task automatic resetDut();
      applyStimulus(0, 0, 0);
      @(posedge clock);
      #2;
      rstN = 1'b0;
      idleCycle();
      rstN = 1'b1;
      idleCycle();
   endtask

   task automatic startShot(input int tag, input bit sel, input bit rs, input int lv);
      applyStimulus(1, 0, rs);
      checkOutput(tag, sel, 10, 0, 0);
      applyStimulus(0, 0, rs);
      checkOutput(tag, sel, lv, 0, 1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Test 1: reset values, full countdown, buzz length, ignored edge in EXPIRED
      checkOutput(1, 0, 10, 0, 0);
      rstN = 1'b1;
      checkOutput(1, 0, 10, 0, 0);
      startShot(1, 0, 0, 10);
      for (int v = 9; v >= 1; v--) checkOutput(1, 0, v, 0, 1);
      checkOutput(1, 0, 0, 1, 0);
      applyStimulus(1, 0, 0);
      checkOutput(1, 0, 0, 1, 0);
      applyStimulus(0, 0, 0);
      checkOutput(1, 0, 0, 1, 0);
      for (int i = 0; i < 4; i++) checkOutput(1, 0, 10, 0, 0);

      // Test 2: shoot held high 80 ns gives one start; a later edge reloads
      resetDut();
      applyStimulus(1, 0, 0);
      checkOutput(2, 0, 10, 0, 0);
      for (int v = 10; v >= 4; v--) checkOutput(2, 0, v, 0, 1);
      applyStimulus(0, 0, 0);
      checkOutput(2, 0, 3, 0, 1);
      applyStimulus(1, 0, 0);
      checkOutput(2, 0, 2, 0, 1);
      applyStimulus(0, 0, 0);
      checkOutput(2, 0, 10, 0, 1);
      checkOutput(2, 0, 9, 0, 1);
      checkOutput(2, 0, 8, 0, 1);

      // Test 3: short restart at count 8, expiry five ticks after the reload
      resetDut();
      startShot(3, 0, 0, 10);
      checkOutput(3, 0, 9, 0, 1);
      checkOutput(3, 0, 8, 0, 1);
      applyStimulus(1, 0, 1);
      checkOutput(3, 0, 7, 0, 1);
      applyStimulus(0, 0, 1);
      checkOutput(3, 0, 5, 0, 1);
      applyStimulus(0, 0, 0);
      for (int v = 4; v >= 1; v--) checkOutput(3, 0, v, 0, 1);
      checkOutput(3, 0, 0, 1, 0);

      // Test 4: hold at count 6 for 20 cycles, then resume
      resetDut();
      startShot(4, 0, 0, 10);
      for (int v = 9; v >= 6; v--) checkOutput(4, 0, v, 0, 1);
      applyStimulus(0, 1, 0);
      for (int i = 0; i < 20; i++) checkOutput(4, 0, 6, 0, 0);
      applyStimulus(0, 0, 0);
      checkOutput(4, 0, 6, 0, 1);
      checkOutput(4, 0, 5, 0, 1);

      // Test 5: asynchronous reset while buzzing and mid-count
      resetDut();
      startShot(5, 0, 0, 10);
      for (int v = 9; v >= 1; v--) checkOutput(5, 0, v, 0, 1);
      checkOutput(5, 0, 0, 1, 0);
      resetStep(5, 0);
      checkOutput(5, 0, 10, 0, 0);
      rstN = 1'b1;
      checkOutput(5, 0, 10, 0, 0);
      startShot(5, 0, 0, 10);
      for (int v = 9; v >= 3; v--) checkOutput(5, 0, v, 0, 1);
      resetStep(5, 0);
      rstN = 1'b1;
      checkOutput(5, 0, 10, 0, 0);

      // Test 6: prescaler of 4 holds each value four cycles
      resetDut();
      startShot(6, 1, 0, 10);
      for (int k = 0; k < 3; k++) checkOutput(6, 1, 10, 0, 1);
      for (int v = 9; v >= 1; v--)
         for (int k = 0; k < 4; k++) checkOutput(6, 1, v, 0, 1);
      checkOutput(6, 1, 0, 1, 0);
      checkOutput(6, 1, 0, 1, 0);
      checkOutput(6, 1, 0, 1, 0);
      checkOutput(6, 1, 10, 0, 0);

      @(negedge clock);
      #1;
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain pending expectations got %0d required 0", expQ.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
